// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw active-low key pins in, conditioned per-key
// level / press / release flags out.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] keys;          // raw pins, 0 = pressed
  logic [N_KEYS-1:0] keys_level;    // debounced state, 1 = pressed
  logic [N_KEYS-1:0] keys_press;    // one-cycle press / auto-repeat pulse
  logic [N_KEYS-1:0] keys_release;  // one-cycle release pulse

  // Producer of the raw pins, consumer of the conditioned flags.
  modport master (
    output keys,
    input  keys_level,
    input  keys_press,
    input  keys_release
  );

  // The conditioner itself.
  modport slave (
    input  keys,
    output keys_level,
    output keys_press,
    output keys_release
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, per-key debounce counter and
// a small FSM per key that produces a clean level, a press pulse with
// optional auto-repeat, and a release pulse. Keys are fully independent.
module key_conditioner #(
  parameter int                 N_KEYS          = 4,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 5000000,
  parameter logic [N_KEYS-1:0]  REPEAT_MASK     = 4'b0011,
  parameter int                 CNT_W           = 25
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  key_conditioner_if.slave bus
);

  // Terminal counts: every counter is compared for equality and cleared on
  // match, so it never wraps.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,  // released
    PRESSIONADO = 2'd1,  // held, waiting for first repeat
    REPETINDO   = 2'd2   // held, periodic repeat
  } state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;

  // Two-flop synchroniser for the asynchronous pins; resets to "released".
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= {N_KEYS{1'b1}};
      r_sync2 <= {N_KEYS{1'b1}};
    end else begin
      r_sync1 <= bus.keys;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t           r_state;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_sync;
    logic             w_diff;
    logic             w_deb_hit;

    // Synchronised pin, inverted so that 1 means pressed.
    assign w_sync    = ~r_sync2[i];
    assign w_diff    = (w_sync != r_level);
    // A level change is accepted once it has been stable long enough.
    assign w_deb_hit = w_diff && (r_deb_cnt == DEB_LAST);

    // Debounce counter plus key FSM; press/release are registered pulses.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        r_state   <= SOLTO;
        r_deb_cnt <= '0;
        r_rep_cnt <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        // Any bounce back to the accepted level restarts the count.
        if (!w_diff || w_deb_hit) begin
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + CNT_ONE;
        end

        r_press   <= 1'b0;
        r_release <= 1'b0;

        case (r_state)
          SOLTO: begin
            r_rep_cnt <= '0;
            if (w_deb_hit) begin
              r_level <= 1'b1;
              r_press <= 1'b1;
              r_state <= PRESSIONADO;
            end
          end
          PRESSIONADO: begin
            if (w_deb_hit) begin
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_rep_cnt <= '0;
              r_state   <= SOLTO;
            end else if (REPEAT_MASK[i]) begin
              if (r_rep_cnt == DELAY_LAST) begin
                r_press   <= 1'b1;
                r_rep_cnt <= '0;
                r_state   <= REPETINDO;
              end else begin
                r_rep_cnt <= r_rep_cnt + CNT_ONE;
              end
            end else begin
              r_rep_cnt <= '0;
            end
          end
          REPETINDO: begin
            // Release has priority over a repeat due on the same edge.
            if (w_deb_hit) begin
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_rep_cnt <= '0;
              r_state   <= SOLTO;
            end else if (r_rep_cnt == PER_LAST) begin
              r_press   <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state   <= SOLTO;
            r_rep_cnt <= '0;
            r_level   <= 1'b0;
          end
        endcase
      end
    end

    assign w_level[i]   = r_level;
    assign w_press[i]   = r_press;
    assign w_release[i] = r_release;
  end

  assign bus.keys_level   = w_level;
  assign bus.keys_press   = w_press;
  assign bus.keys_release = w_release;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing parameters
// (debounce 4, repeat delay 10, repeat period 3, repeat only on key 0).
// Edge e = 0 is the first rising edge after reset deasserts; a raw value
// applied before edge k is reflected on keys_level at edge k + 5.
module tb_key_conditioner;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  key_conditioner_if #(.N_KEYS(N)) kif ();

  key_conditioner #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (4'b0001),
    .CNT_W           (25)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (kif)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ph, input int e,
                           input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
    check_eq($sformatf("%s e=%0d level", ph, e), kif.keys_level, lvl);
    check_eq($sformatf("%s e=%0d press", ph, e), kif.keys_press, prs);
    check_eq($sformatf("%s e=%0d release", ph, e), kif.keys_release, rel);
  endtask

  // Sample #1 after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given raw pins held; next rising edge is e = 0.
  task automatic restart(input logic [3:0] k);
    rst = 1'b1;
    kif.keys = k;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Phase 2: key 0 held from edge 10, pin returns high at edge 41.
  function automatic logic [3:0] p2_keys(input int e);
    return (e >= 10 && e < 41) ? 4'b1110 : 4'b1111;
  endfunction

  // Phase 3 pins: key0 low from 20, key1 low 10..39, key2 bounces
  // (3 low, 1 high, 2 low), key3 low 20..34.
  function automatic logic [3:0] p3_keys(input int e);
    logic [3:0] v;
    v = 4'b1111;
    if (e >= 20) v[0] = 1'b0;
    if (e >= 10 && e < 40) v[1] = 1'b0;
    if (e == 10 || e == 11 || e == 12 || e == 14 || e == 15) v[2] = 1'b0;
    if (e >= 20 && e < 35) v[3] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] p3_lvl(input int e);
    logic [3:0] v;
    v = 4'b0000;
    v[0] = (e >= 25);
    v[1] = (e >= 15 && e < 45);
    v[3] = (e >= 25 && e < 40);
    return v;
  endfunction

  function automatic logic [3:0] p3_prs(input int e);
    logic [3:0] v;
    v = 4'b0000;
    v[0] = (e == 25) || (e >= 35 && (e - 35) % 3 == 0);
    v[1] = (e == 15);
    v[3] = (e == 25);
    return v;
  endfunction

  function automatic logic [3:0] p3_rel(input int e);
    logic [3:0] v;
    v = 4'b0000;
    v[1] = (e == 45);
    v[3] = (e == 40);
    return v;
  endfunction

  initial begin
    rst = 1'b0;
    kif.keys = 4'b0000;

    // Phase 1: reset with all keys held, outputs zero without any edge.
    #1;
    rst = 1'b1;
    #1;
    check_all("reset", 0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      tick();
      check_all("allheld", e,
                (e >= 5) ? 4'b1111 : 4'b0000,
                (e == 5) ? 4'b1111 : ((e == 15) ? 4'b0001 : 4'b0000),
                4'b0000);
    end

    // Phase 2: key 0 auto-repeat, release landing on a repeat edge (46).
    restart(p2_keys(0));
    for (int e = 0; e <= 50; e++) begin
      tick();
      check_all("repeat", e,
                (e >= 15 && e < 46) ? 4'b0001 : 4'b0000,
                ((e == 15) || (e >= 25 && e < 46 && (e - 25) % 3 == 0)) ? 4'b0001 : 4'b0000,
                (e == 46) ? 4'b0001 : 4'b0000);
      kif.keys = p2_keys(e + 1);
    end

    // Phase 3: no-repeat key, bounce rejection, simultaneous press.
    restart(p3_keys(0));
    for (int e = 0; e <= 50; e++) begin
      tick();
      check_all("multi", e, p3_lvl(e), p3_prs(e), p3_rel(e));
      kif.keys = p3_keys(e + 1);
    end

    // Phase 4: reset while key 0 is held drops outputs at once, then a
    // fresh single press follows the normal latency.
    rst = 1'b1;
    #1;
    check_all("midreset", 0, 4'b0000, 4'b0000, 4'b0000);
    kif.keys = 4'b1110;
    tick();
    tick();
    rst = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check_all("afterreset", e,
                (e >= 5) ? 4'b0001 : 4'b0000,
                (e == 5) ? 4'b0001 : 4'b0000,
                4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
